cv32e41p_zcmp_sequencer: RTL and testbench

- Parametrised micro-op sequencer for Zcmp: cm.push, cm.pop, cm.popret, cm.popretz, cm.mvsa01, cm.mva01s.
- Sits between the IF aligner and the ID decoder.
- Expands each Zcmp instruction into a stream of RV32I micro-ops over a valid/ready handshake. Every other instruction passes straight through.
- New behaviour versus the previous sequencer: it captures the instruction and frees fetch at the first micro-op, honours full backpressure, supports flush, flags illegal encodings, and parametrises stack alignment and the maximum register list.

---
 rtl/cv32e41p_zcmp_pkg.sv | 107 ++++++++++
 rtl/cv32e41p_zcmp_sequencer_if.sv | 25 ++
 rtl/cv32e41p_zcmp_uop_gen.sv | 86 ++++++++
 rtl/cv32e41p_zcmp_sequencer.sv | 142 ++++++++++++++
 tb/tb_cv32e41p_zcmp_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e41p_zcmp_pkg.sv
// Shared types, opcode constants and arithmetic helpers for the Zcmp micro-op sequencer.
package cv32e41p_zcmp_pkg;

  typedef enum logic [2:0] {
    NONE,
    PUSH,
    POP,
    POPRET,
    POPRETZ,
    MVSA01,
    MVA01S
  } zcmp_kind_e;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } seq_state_e;

  typedef struct packed {
    zcmp_kind_e kind;
    logic [3:0] rlist;
    logic [1:0] spimm;
    logic [2:0] r1s;
    logic [2:0] r2s;
  } zcmp_cap_t;

  localparam zcmp_cap_t CAP_RST = '{kind: NONE, rlist: 4'd0, spimm: 2'd0, r1s: 3'd0, r2s: 3'd0};

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [2:0] F3_W      = 3'b010;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] REG_RA    = 5'd1;
  localparam logic [4:0] REG_SP    = 5'd2;
  localparam logic [4:0] REG_A0    = 5'd10;
  localparam logic [4:0] REG_A1    = 5'd11;

  function automatic zcmp_kind_e zcmp_decode(input logic [15:0] ins);
    zcmp_kind_e k;
    k = NONE;
    if (ins[1:0] == 2'b10) begin
      case (ins[15:10])
        6'b101110: begin
          if (ins[9:8] == 2'b00) k = PUSH;
          else if (ins[9:8] == 2'b10) k = POP;
          else k = NONE;
        end
        6'b101111: begin
          if (ins[9:8] == 2'b00) k = POPRETZ;
          else if (ins[9:8] == 2'b10) k = POPRET;
          else k = NONE;
        end
        6'b101011: begin
          if (ins[6:5] == 2'b01) k = MVSA01;
          else if (ins[6:5] == 2'b11) k = MVA01S;
          else k = NONE;
        end
        default: k = NONE;
      endcase
    end else begin
      k = NONE;
    end
    return k;
  endfunction

  // rlist 15 covers s10 and s11 together, hence 13 rather than 12 registers
  function automatic logic [3:0] rlist_to_n(input logic [3:0] rlist);
    if (rlist == 4'd15) return 4'd13;
    else return rlist - 4'd3;
  endfunction

  function automatic logic [11:0] stack_adj(input logic [3:0] n, input logic [1:0] spimm,
                                            input int align);
    logic [11:0] bytes_v;
    logic [11:0] mask_v;
    bytes_v = {6'd0, n, 2'b00};
    mask_v  = 12'(align - 1);
    return ((bytes_v + mask_v) & ~mask_v) + {6'd0, spimm, 4'd0};
  endfunction

  function automatic logic [4:0] sidx_to_regnum(input logic [3:0] idx);
    if (idx == 4'd0) return REG_RA;
    else if (idx == 4'd1) return 5'd8;
    else if (idx == 4'd2) return 5'd9;
    else return {1'b0, idx} + 5'd15;
  endfunction

  function automatic logic [4:0] sreg_prime_to_regnum(input logic [2:0] s);
    if (s == 3'd0) return 5'd8;
    else if (s == 3'd1) return 5'd9;
    else return {2'b00, s} + 5'd16;
  endfunction

  function automatic logic [31:0] enc_itype(input logic [6:0] opc, input logic [4:0] rd,
                                            input logic [2:0] f3, input logic [4:0] rs1,
                                            input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, REG_SP, F3_W, imm[4:0], OPC_STORE};
  endfunction

endpackage

// File: rtl/cv32e41p_zcmp_sequencer_if.sv
// Instruction-in / micro-op-out handshake bundle; slave is the sequencer, master its environment.
interface cv32e41p_zcmp_sequencer_if;
  logic        flush_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] uop_o;
  logic        uop_valid_o;
  logic        uop_ready_i;
  logic        uop_first_o;
  logic        uop_last_o;
  logic        is_seq_o;
  logic        illegal_o;
  logic        busy_o;

  modport master (
    output flush_i, instr_i, instr_valid_i, uop_ready_i,
    input  instr_ready_o, uop_o, uop_valid_o, uop_first_o, uop_last_o, is_seq_o, illegal_o, busy_o
  );

  modport slave (
    input  flush_i, instr_i, instr_valid_i, uop_ready_i,
    output instr_ready_o, uop_o, uop_valid_o, uop_first_o, uop_last_o, is_seq_o, illegal_o, busy_o
  );
endinterface

// File: rtl/cv32e41p_zcmp_uop_gen.sv
// Combinational expansion of one captured Zcmp instruction: micro-op at index cnt_i and
// the index of the final micro-op.
module cv32e41p_zcmp_uop_gen
  import cv32e41p_zcmp_pkg::*;
#(
  parameter int STACK_ALIGN = 16,
  parameter int SEQ_W       = 4
) (
  input  zcmp_cap_t        cap_i,
  input  logic [SEQ_W-1:0] cnt_i,
  output logic [31:0]      uop_o,
  output logic [SEQ_W-1:0] last_idx_o
);

  localparam logic [SEQ_W-1:0] CNT_ZERO = {SEQ_W{1'b0}};
  localparam logic [SEQ_W-1:0] CNT_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};

  logic [3:0]       n_s;
  logic [3:0]       idx_s;
  logic [SEQ_W-1:0] n_w_s;
  logic [11:0]      adj_s;
  logic [11:0]      off_s;
  logic [4:0]       sreg_s;
  logic [4:0]       r1_s;
  logic [4:0]       r2_s;
  logic [31:0]      load_s;
  logic [31:0]      sp_up_s;
  logic [31:0]      ret_s;

  // slot i < n moves register i; the tail slots adjust sp, clear a0 and return
  always_comb begin
    n_s     = rlist_to_n(cap_i.rlist);
    n_w_s   = SEQ_W'(n_s);
    idx_s   = 4'(cnt_i);
    adj_s   = stack_adj(n_s, cap_i.spimm, STACK_ALIGN);
    off_s   = {6'd0, idx_s + 4'd1, 2'b00};
    sreg_s  = sidx_to_regnum(idx_s);
    r1_s    = sreg_prime_to_regnum(cap_i.r1s);
    r2_s    = sreg_prime_to_regnum(cap_i.r2s);
    load_s  = enc_itype(OPC_LOAD, sreg_s, F3_W, REG_SP, adj_s - off_s);
    sp_up_s = enc_itype(OPC_OPIMM, REG_SP, F3_ADDI, REG_SP, adj_s);
    ret_s   = enc_itype(OPC_JALR, REG_ZERO, F3_ADDI, REG_RA, 12'd0);
    uop_o      = 32'd0;
    last_idx_o = CNT_ZERO;
    case (cap_i.kind)
      PUSH: begin
        last_idx_o = n_w_s;
        if (cnt_i < n_w_s) uop_o = enc_sw(sreg_s, 12'd0 - off_s);
        else uop_o = enc_itype(OPC_OPIMM, REG_SP, F3_ADDI, REG_SP, 12'd0 - adj_s);
      end
      POP: begin
        last_idx_o = n_w_s;
        if (cnt_i < n_w_s) uop_o = load_s;
        else uop_o = sp_up_s;
      end
      POPRET: begin
        last_idx_o = n_w_s + CNT_ONE;
        if (cnt_i < n_w_s) uop_o = load_s;
        else if (cnt_i == n_w_s) uop_o = sp_up_s;
        else uop_o = ret_s;
      end
      POPRETZ: begin
        last_idx_o = n_w_s + CNT_ONE + CNT_ONE;
        if (cnt_i < n_w_s) uop_o = load_s;
        else if (cnt_i == n_w_s) uop_o = enc_itype(OPC_OPIMM, REG_A0, F3_ADDI, REG_ZERO, 12'd0);
        else if (cnt_i == n_w_s + CNT_ONE) uop_o = sp_up_s;
        else uop_o = ret_s;
      end
      MVSA01: begin
        last_idx_o = CNT_ONE;
        if (cnt_i == CNT_ZERO) uop_o = enc_itype(OPC_OPIMM, r1_s, F3_ADDI, REG_A0, 12'd0);
        else uop_o = enc_itype(OPC_OPIMM, r2_s, F3_ADDI, REG_A1, 12'd0);
      end
      MVA01S: begin
        last_idx_o = CNT_ONE;
        if (cnt_i == CNT_ZERO) uop_o = enc_itype(OPC_OPIMM, REG_A0, F3_ADDI, r1_s, 12'd0);
        else uop_o = enc_itype(OPC_OPIMM, REG_A1, F3_ADDI, r2_s, 12'd0);
      end
      default: begin
        uop_o      = 32'd0;
        last_idx_o = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/cv32e41p_zcmp_sequencer.sv
// Zcmp micro-op sequencer between IF aligner and ID decoder: expands push/pop/popret(z)/mv*
// into RV32I micro-ops; all other instructions pass straight through.
module cv32e41p_zcmp_sequencer
  import cv32e41p_zcmp_pkg::*;
#(
  parameter int STACK_ALIGN = 16,
  parameter int MAX_RLIST   = 15,
  parameter int SEQ_W       = 4
) (
  input logic                      clk,
  input logic                      n_rst,
  cv32e41p_zcmp_sequencer_if.slave bus
);

  localparam logic [SEQ_W-1:0] CNT_ZERO = {SEQ_W{1'b0}};
  localparam logic [SEQ_W-1:0] CNT_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       MAX_RL   = 4'(MAX_RLIST);

  seq_state_e       state_q, state_d;
  logic [SEQ_W-1:0] cnt_q, cnt_d;
  zcmp_cap_t        cap_q, cap_d;

  zcmp_kind_e       dec_kind_s;
  zcmp_cap_t        dec_cap_s;
  logic             dec_illegal_s;
  logic             dec_seq_s;
  zcmp_cap_t        gen_cap_s;
  logic [SEQ_W-1:0] gen_cnt_s;
  logic [31:0]      gen_uop_s;
  logic [SEQ_W-1:0] last_idx_s;

  // decode and legality of the instruction currently offered by the aligner
  always_comb begin
    dec_kind_s = zcmp_decode(bus.instr_i[15:0]);
    dec_cap_s  = '{kind: dec_kind_s, rlist: bus.instr_i[7:4], spimm: bus.instr_i[3:2],
                   r1s: bus.instr_i[9:7], r2s: bus.instr_i[4:2]};
    case (dec_kind_s)
      PUSH, POP, POPRET, POPRETZ: dec_illegal_s = (dec_cap_s.rlist < 4'd4) || (dec_cap_s.rlist > MAX_RL);
      MVSA01:                     dec_illegal_s = (dec_cap_s.r1s == dec_cap_s.r2s);
      default:                    dec_illegal_s = 1'b0;
    endcase
    dec_seq_s = (dec_kind_s != NONE) && !dec_illegal_s;
  end

  // one generator serves both the live instruction (slot 0) and the captured one
  always_comb begin
    if (state_q == ST_RUN) begin
      gen_cap_s = cap_q;
      gen_cnt_s = cnt_q;
    end else begin
      gen_cap_s = dec_cap_s;
      gen_cnt_s = CNT_ZERO;
    end
  end

  cv32e41p_zcmp_uop_gen #(
    .STACK_ALIGN (STACK_ALIGN),
    .SEQ_W       (SEQ_W)
  ) u_uop_gen (
    .cap_i      (gen_cap_s),
    .cnt_i      (gen_cnt_s),
    .uop_o      (gen_uop_s),
    .last_idx_o (last_idx_s)
  );

  // output muxing and next-state; flush outranks every handshake
  always_comb begin
    bus.uop_o         = bus.instr_i;
    bus.uop_valid_o   = bus.instr_valid_i;
    bus.instr_ready_o = bus.uop_ready_i;
    bus.uop_first_o   = 1'b1;
    bus.uop_last_o    = 1'b1;
    bus.is_seq_o      = 1'b0;
    bus.illegal_o     = dec_illegal_s;
    bus.busy_o        = 1'b0;
    state_d           = state_q;
    cnt_d             = cnt_q;
    cap_d             = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (dec_seq_s) begin
          bus.uop_o      = gen_uop_s;
          bus.uop_last_o = (last_idx_s == CNT_ZERO);
          bus.is_seq_o   = 1'b1;
        end else begin
          bus.is_seq_o   = 1'b0;
        end
        if (bus.flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (bus.instr_valid_i && bus.uop_ready_i && dec_seq_s) begin
          cap_d   = dec_cap_s;
          cnt_d   = CNT_ONE;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        bus.uop_o         = gen_uop_s;
        bus.uop_valid_o   = !bus.flush_i;
        bus.instr_ready_o = 1'b0;
        bus.uop_first_o   = (cnt_q == CNT_ZERO);
        bus.uop_last_o    = (cnt_q == last_idx_s);
        bus.is_seq_o      = 1'b1;
        bus.illegal_o     = 1'b0;
        bus.busy_o        = 1'b1;
        if (bus.flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (bus.uop_ready_i) begin
          if (cnt_q == last_idx_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // sequencer state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      cap_q   <= CAP_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

endmodule

// File: tb/tb_cv32e41p_zcmp_sequencer.sv
// Scoreboard bench: expected micro-ops are queued when an instruction is driven and
// compared on every accepted micro-op.
module tb_cv32e41p_zcmp_sequencer;

  typedef struct {
    logic [31:0] uop;
    logic        first;
    logic        last;
    logic        seq;
    logic        ill;
  } exp_t;

  logic clk;
  logic n_rst;
  int   n_cmp;
  int   n_err;
  int   cons;
  exp_t sb[$];
  int   sregs[13] = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};

  logic        stall_q;
  logic [31:0] held_uop_q;
  logic [3:0]  held_flags_q;

  cv32e41p_zcmp_sequencer_if bus ();
  cv32e41p_zcmp_sequencer_if bus8 ();

  cv32e41p_zcmp_sequencer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  cv32e41p_zcmp_sequencer #(.MAX_RLIST(8)) dut8 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] im;
    logic [4:0]  d;
    logic [4:0]  s;
    im = imm[11:0];
    d  = rd[4:0];
    s  = rs1[4:0];
    return {im, s, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_sw(input int rs2, input int imm);
    logic [11:0] im;
    logic [4:0]  r;
    im = imm[11:0];
    r  = rs2[4:0];
    return {im[11:5], r, 5'd2, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lw(input int rd, input int imm);
    logic [11:0] im;
    logic [4:0]  d;
    im = imm[11:0];
    d  = rd[4:0];
    return {im, 5'd2, 3'b010, d, 7'b0000011};
  endfunction

  task automatic push_exp(input logic [31:0] u, input logic f, input logic l,
                          input logic s, input logic i);
    exp_t e;
    e.uop = u; e.first = f; e.last = l; e.seq = s; e.ill = i;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input bit toggle, output int cons_cyc);
    bit done;
    bit consumed;
    done     = 1'b0;
    cons_cyc = -1;
    bus.instr_i       = ins;
    bus.instr_valid_i = 1'b1;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      bus.uop_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      consumed = bus.instr_valid_i && bus.instr_ready_o && bus.uop_ready_i;
      if (consumed) cons_cyc = cyc;
      if (bus.uop_valid_o && bus.uop_ready_i && bus.uop_last_o) done = 1'b1;
      tick();
      if (consumed) bus.instr_valid_i = 1'b0;
    end
    bus.instr_valid_i = 1'b0;
    bus.uop_ready_i   = 1'b1;
    if (!done) chk("seq_timeout", 32'd0, 32'd1);
  endtask

  // scoreboard pop on every accepted micro-op, plus hold check after each stall
  always @(negedge clk) begin
    if (n_rst && bus.uop_valid_o && bus.uop_ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_uop", bus.uop_o, 32'd0);
      end else begin
        chk("uop", bus.uop_o, sb[0].uop);
        chk("first", {31'd0, bus.uop_first_o}, {31'd0, sb[0].first});
        chk("last", {31'd0, bus.uop_last_o}, {31'd0, sb[0].last});
        chk("is_seq", {31'd0, bus.is_seq_o}, {31'd0, sb[0].seq});
        chk("illegal", {31'd0, bus.illegal_o}, {31'd0, sb[0].ill});
        void'(sb.pop_front());
      end
    end
    if (n_rst && stall_q && bus.uop_valid_o) begin
      chk("stall_uop_hold", bus.uop_o, held_uop_q);
      chk("stall_flag_hold", {28'd0, bus.uop_first_o, bus.uop_last_o, bus.is_seq_o, bus.illegal_o},
          {28'd0, held_flags_q});
    end
    stall_q      <= n_rst && !bus.flush_i && bus.uop_valid_o && !bus.uop_ready_i;
    held_uop_q   <= bus.uop_o;
    held_flags_q <= {bus.uop_first_o, bus.uop_last_o, bus.is_seq_o, bus.illegal_o};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    stall_q = 1'b0;
    n_rst = 1'b0;
    bus.flush_i = 1'b0;  bus.instr_i = 32'd0;  bus.instr_valid_i = 1'b0;  bus.uop_ready_i = 1'b1;
    bus8.flush_i = 1'b0; bus8.instr_i = 32'd0; bus8.instr_valid_i = 1'b0; bus8.uop_ready_i = 1'b0;

    // reset state: outputs follow the live instruction
    bus.instr_i = 32'h00730293;
    bus.instr_valid_i = 1'b1;
    #12;
    chk("rst_valid", {31'd0, bus.uop_valid_o}, 32'd1);
    chk("rst_uop", bus.uop_o, 32'h00730293);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_first_last", {30'd0, bus.uop_first_o, bus.uop_last_o}, 32'd3);
    chk("rst_is_seq", {31'd0, bus.is_seq_o}, 32'd0);
    bus.instr_valid_i = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("rst_idle_valid", {31'd0, bus.uop_valid_o}, 32'd0);

    // cm.push {ra,s0-s1},-32
    push_exp(32'hFE112E23, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_sw(8, -8), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(enc_sw(9, -12), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(2, 2, -32), 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000B866, 1'b0, cons);
    chk("push_consume_cycle", cons, 32'd0);
    chk("push_back_idle", {31'd0, bus.busy_o}, 32'd0);

    // cm.pop {ra,s0},48
    push_exp(enc_lw(1, 44), 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_lw(8, 40), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(2, 2, 48), 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000BA5A, 1'b0, cons);

    // cm.popret rlist=15: all 13 saved registers
    for (int i = 0; i < 13; i++) push_exp(enc_lw(sregs[i], 60 - 4 * i), i == 0, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(2, 2, 64), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(32'h00008067, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000BEF2, 1'b0, cons);

    // cm.popretz rlist=4 under 1010 backpressure
    push_exp(enc_lw(1, 12), 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(10, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(2, 2, 16), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(32'h00008067, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000BC42, 1'b1, cons);
    chk("popretz_consume_cycle", cons, 32'd0);

    // register moves
    push_exp(enc_addi(8, 10, 0), 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(9, 11, 0), 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000AC26, 1'b0, cons);
    push_exp(enc_addi(10, 18, 0), 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(11, 23, 0), 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000AD7E, 1'b0, cons);

    // illegal encodings pass through as a single uop
    push_exp(32'h0000B832, 1'b1, 1'b1, 1'b0, 1'b1);
    run_instr(32'h0000B832, 1'b0, cons);
    push_exp(32'h0000ADAE, 1'b1, 1'b1, 1'b0, 1'b1);
    run_instr(32'h0000ADAE, 1'b0, cons);
    chk("illegal_no_run", {31'd0, bus.busy_o}, 32'd0);

    // plain 32-bit passthrough
    push_exp(32'h00730293, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(32'h00730293, 1'b0, cons);

    // flush during uop 2 of a push
    push_exp(32'hFE112E23, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_sw(8, -8), 1'b0, 1'b0, 1'b1, 1'b0);
    bus.instr_i = 32'h0000B866;
    bus.instr_valid_i = 1'b1;
    bus.uop_ready_i = 1'b1;
    tick();
    bus.instr_valid_i = 1'b0;
    tick();
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_valid_low", {31'd0, bus.uop_valid_o}, 32'd0);
    tick();
    bus.flush_i = 1'b0;
    chk("flush_idle", {31'd0, bus.busy_o}, 32'd0);
    push_exp(enc_lw(1, 44), 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_lw(8, 40), 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(enc_addi(2, 2, 48), 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(32'h0000BA5A, 1'b0, cons);

    // asynchronous reset mid-sequence
    push_exp(32'hFE112E23, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(enc_sw(8, -8), 1'b0, 1'b0, 1'b1, 1'b0);
    bus.instr_i = 32'h0000B866;
    bus.instr_valid_i = 1'b1;
    tick();
    bus.instr_valid_i = 1'b0;
    tick();
    chk("pre_reset_busy", {31'd0, bus.busy_o}, 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_reset_idle", {31'd0, bus.busy_o}, 32'd0);
    chk("async_reset_valid", {31'd0, bus.uop_valid_o}, 32'd0);
    tick();
    n_rst = 1'b1;
    push_exp(32'h00730293, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(32'h00730293, 1'b0, cons);

    // reduced register list core: rlist 8 legal, 9 illegal
    bus8.instr_i = 32'h0000B882;
    bus8.instr_valid_i = 1'b1;
    bus8.uop_ready_i = 1'b0;
    @(negedge clk);
    chk("max8_rlist8_seq", {30'd0, bus8.is_seq_o, bus8.illegal_o}, 32'd2);
    tick();
    bus8.instr_i = 32'h0000B892;
    bus8.uop_ready_i = 1'b1;
    @(negedge clk);
    chk("max8_rlist9_illegal", {31'd0, bus8.illegal_o}, 32'd1);
    chk("max8_rlist9_uop", bus8.uop_o, 32'h0000B892);
    chk("max8_rlist9_flags", {29'd0, bus8.uop_first_o, bus8.uop_last_o, bus8.is_seq_o}, 32'd6);
    chk("max8_rlist9_ready", {31'd0, bus8.instr_ready_o}, 32'd1);
    tick();
    bus8.instr_valid_i = 1'b0;
    chk("max8_no_run", {31'd0, bus8.busy_o}, 32'd0);

    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
